sorted_pair_reader: RTL
=======================

Name: sorted_pair_reader

Overview:
- Read-side counterpart of the pair loader: once sorting finishes, streams the sorted tuple pairs back out of the selected ping/pong memory.
- Issues even/odd bank reads at stride 2 and buffers the returned data.
- Presents one even/odd pair per beat on a valid/ready interface.
- Sits between the ping/pong banks and the downstream consumer, i.e. the range-merge/answer logic or a bench dump.

Parameters:
- RD_LATENCY, 1, bank read latency in cycles, from rd_en_out to valid rd_*_data_in; legal range 1..3.
- FIFO_DEPTH, RD_LATENCY+2, entries in the return buffer; each entry holds one even/odd pair.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start_in  in  1  single-cycle pulse that begins a read-out; ignored while busy_out=1.
- bank_sel_in  in  1  0=ping, 1=pong; sampled on start_in.
- pair_count_in  in  `BANK_ADDR_WIDTH+1  number of tuple pairs to emit; sampled on start_in.
- rd_en_out  out  1  read strobe to both banks of the selected memory.
- rd_bank_sel_out  out  1  registered copy of bank_sel_in.
- rd_addr_out  out  `BANK_ADDR_WIDTH  logical even address; the same address is driven to both banks.
- rd_even_data_in  in  tuple_pair_t  even-bank return data, valid RD_LATENCY cycles after rd_en_out.
- rd_odd_data_in  in  tuple_pair_t  odd-bank return data, same timing.
- out_valid_out  out  1  output beat valid.
- out_ready_in  in  1  consumer accepts the beat when out_valid_out & out_ready_in.
- even_data_out  out  tuple_pair_t  pair at logical address 2k.
- odd_data_out  out  tuple_pair_t  pair at 2k+1.
- odd_lane_valid_out  out  1  0 only on the final beat of an odd pair_count.
- busy_out  out  1  high from the cycle after start_in until the cycle done_out is asserted.
- done_out  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, reset_n=0) clears:
  - FSM to IDLE, FIFO empty, credit counter = FIFO_DEPTH;
  - rd_en_out=0, rd_addr_out=0, out_valid_out=0, busy_out=0, done_out=0, odd_lane_valid_out=0;
  - data outputs =0.
  - Reset mid-operation abandons the transfer with no done_out, and reads in flight are discarded.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: start_in with pair_count_in>0 latches the count and bank, sets the address to 0 and goes to ISSUE.
  - IDLE: start_in with pair_count_in=0 goes to FINISH directly, so done_out pulses the next cycle and no reads are issued.
  - ISSUE: rd_en_out=1 in any cycle where credits>0. On that cycle the address increments by 2 and credits decrement.
  - ISSUE leaves for DRAIN once ceil(count/2) reads have been issued.
  - DRAIN waits until all reads have returned and the FIFO is empty with its last beat accepted, then goes to FINISH.
  - FINISH: done_out=1 for one cycle, then IDLE.
- Credits:
  - A credit returns when a beat is accepted; the counter can see a decrement and an increment in the same cycle.
  - Reads are therefore never issued without FIFO space, so return data is never dropped under backpressure.
- Return path:
  - A RD_LATENCY-deep valid shift register tags returning data for FIFO push.
  - The last-beat tag carries odd_lane_valid=~count[0].
- Output:
  - out_valid_out, even_data_out and odd_data_out are driven from the FIFO head.
  - Outputs hold stable while out_valid_out=1 and out_ready_in=0.
- Throughput: one beat per cycle with out_ready_in held high.
- First-beat latency: RD_LATENCY+2 cycles from start_in.
- Address width: the address wraps modulo 2^`BANK_ADDR_WIDTH. pair_count_in greater than bank capacity is illegal; the block does not check it.
- Simultaneous events: start_in during busy is ignored; a FIFO push and pop in the same cycle keeps the occupancy unchanged.

Optional Feature:
- Macro: SORT_CHECK_EN.
- When defined:
  - Adds port order_error_out (out, 1), reset 0.
  - It goes sticky-high if any emitted pair's .first is below the previous emitted pair's .first, in stream order even then odd, across beats.
  - It clears on the next accepted start_in.
- When undefined: the port and comparator logic are absent, and all other behaviour is identical.

Test Plan:
- Ping holds pairs (1,5),(3,4),(7,9),(8,8); start, count=4, bank=0, ready=1 → two beats: {(1,5),(3,4)} then {(7,9),(8,8)}. odd_lane_valid=1 on both beats, done_out pulses once, 2 reads at addr 0 and 2.
- Pong, count=5, ready=1 → 3 beats; the third beat has odd_lane_valid_out=0. rd_bank_sel_out=1 throughout.
- count=6, out_ready_in toggles 1,0,0,1,0,1 → data stable while stalled, no beat lost or duplicated, and rd_en_out never raised with credits=0.
- start with count=0 → done_out the next cycle, rd_en_out and out_valid_out never asserted.
- Assert reset_n=0 after the second beat of a count=16 run → all outputs 0 immediately. A new start with count=2 then yields the correct single beat.
- SORT_CHECK_EN build, ping data (2,2),(9,1),(4,4),(10,0) → order_error_out rises on the beat containing (4,4) and stays high until the next start.

Source files
------------

// File: rtl/sorted_pair_reader.sv
// sorted_pair_reader: streams sorted tuple pairs out of the selected ping/pong memory as even/odd beats.
// Optional build macro SORT_CHECK_EN adds order_error_out, a sticky stream-order checker.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 6
`endif

package sorted_pair_reader_pkg;
    typedef struct packed {
        logic [15:0] first;
        logic [15:0] second;
    } tuple_pair_t;
endpackage

module sorted_pair_reader
    import sorted_pair_reader_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start_in,
    input  logic                        bank_sel_in,
    input  logic [`BANK_ADDR_WIDTH:0]   pair_count_in,
    output logic                        rd_en_out,
    output logic                        rd_bank_sel_out,
    output logic [`BANK_ADDR_WIDTH-1:0] rd_addr_out,
    input  tuple_pair_t                 rd_even_data_in,
    input  tuple_pair_t                 rd_odd_data_in,
    output logic                        out_valid_out,
    input  logic                        out_ready_in,
    output tuple_pair_t                 even_data_out,
    output tuple_pair_t                 odd_data_out,
    output logic                        odd_lane_valid_out,
    output logic                        busy_out,
    output logic                        done_out
`ifdef SORT_CHECK_EN
    ,
    output logic                        order_error_out
`endif
);
    localparam int AW  = `BANK_ADDR_WIDTH;
    localparam int CW  = AW + 1;
    localparam int CRW = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    typedef struct packed {
        tuple_pair_t even;
        tuple_pair_t odd;
        logic        odd_lane;
    } entry_t;

    state_t          state_q, state_d;
    logic            count_odd_q;
    logic            bank_q;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   reads_left_q;
    logic [CRW-1:0]  credits_q, credits_d;
    logic [RD_LATENCY-1:0] tag_valid_q, tag_short_q;

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CRW-1:0]  fill_q;
    entry_t          head;

    logic            start_ok, issue, push, pop;
    logic [CW:0]     count_plus_one;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign start_ok       = (state_q == IDLE) && start_in;
    assign issue          = (state_q == ISSUE) && (credits_q != '0);
    assign push           = tag_valid_q[RD_LATENCY-1];
    assign pop            = out_valid_out && out_ready_in;
    assign credits_d      = credits_q - CRW'(issue) + CRW'(pop);
    assign count_plus_one = {1'b0, pair_count_in} + (CW+1)'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Credits equal FIFO_DEPTH again only once every issued read has been popped.
    always_comb begin
        state_d   = state_q;
        rd_en_out = issue;
        busy_out  = (state_q != IDLE);
        done_out  = (state_q == FINISH);
        case (state_q)
            IDLE:    if (start_in) state_d = (pair_count_in == '0) ? FINISH : ISSUE;
            ISSUE:   if (issue && reads_left_q == CW'(1)) state_d = DRAIN;
            DRAIN:   if (credits_d == CRW'(FIFO_DEPTH)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_odd_q  <= 1'b0;
            bank_q       <= 1'b0;
            addr_q       <= '0;
            reads_left_q <= '0;
            credits_q    <= CRW'(FIFO_DEPTH);
            tag_valid_q  <= '0;
            tag_short_q  <= '0;
        end else begin
            if (start_ok) begin
                count_odd_q  <= pair_count_in[0];
                bank_q       <= bank_sel_in;
                addr_q       <= '0;
                reads_left_q <= count_plus_one[CW:1];
            end else if (issue) begin
                addr_q       <= addr_q + AW'(2);
                reads_left_q <= reads_left_q - CW'(1);
            end
            credits_q <= credits_d;
            // The short tag marks the final read of an odd count, whose odd lane is padding.
            tag_valid_q[0] <= issue;
            tag_short_q[0] <= issue && (reads_left_q == CW'(1)) && count_odd_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_short_q[i] <= tag_short_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= '{even: rd_even_data_in, odd: rd_odd_data_in,
                                          odd_lane: ~tag_short_q[RD_LATENCY-1]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            fill_q <= fill_q + CRW'(push) - CRW'(pop);
        end
    end

    assign head               = fifo_mem[rd_ptr_q];
    assign out_valid_out      = (fill_q != '0);
    assign even_data_out      = out_valid_out ? head.even : '0;
    assign odd_data_out       = out_valid_out ? head.odd  : '0;
    assign odd_lane_valid_out = out_valid_out && head.odd_lane;
    assign rd_addr_out        = addr_q;
    assign rd_bank_sel_out    = bank_q;

`ifdef SORT_CHECK_EN
    logic [15:0] prev_first_q;
    logic        have_prev_q;
    logic        order_error_q;
    logic        beat_bad;

    // Stream order is even lane then odd lane, continuing across beats.
    always_comb begin
        beat_bad = 1'b0;
        if (have_prev_q && even_data_out.first < prev_first_q) beat_bad = 1'b1;
        if (odd_lane_valid_out && odd_data_out.first < even_data_out.first) beat_bad = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_first_q  <= '0;
            have_prev_q   <= 1'b0;
            order_error_q <= 1'b0;
        end else if (start_ok) begin
            have_prev_q   <= 1'b0;
            order_error_q <= 1'b0;
        end else if (pop) begin
            if (beat_bad) order_error_q <= 1'b1;
            have_prev_q  <= 1'b1;
            prev_first_q <= odd_lane_valid_out ? odd_data_out.first : even_data_out.first;
        end
    end

    assign order_error_out = order_error_q;
`endif

endmodule
